// File: rtl/hbridge_deadtime_if.sv
// Command and status bundle between the ESC PWM stage and the H-bridge gate driver.
interface hbridge_deadtime_if #(
    parameter int DT_WIDTH  = 8,
    parameter int ILL_WIDTH = 8
);
    logic                 enable_i;
    logic                 drive_pos_i;
    logic                 drive_neg_i;
    logic                 brake_mode_i;
    logic [DT_WIDTH-1:0]  deadtime_cycles_i;
    logic                 fault_n_i;
    logic                 fault_clear_i;
    logic                 gate_ah_o;
    logic                 gate_al_o;
    logic                 gate_bh_o;
    logic                 gate_bl_o;
    logic                 fault_latched_o;
    logic                 dt_active_o;
    logic [ILL_WIDTH-1:0] illegal_cnt_o;

    modport master (
        output enable_i, drive_pos_i, drive_neg_i, brake_mode_i,
               deadtime_cycles_i, fault_n_i, fault_clear_i,
        input  gate_ah_o, gate_al_o, gate_bh_o, gate_bl_o,
               fault_latched_o, dt_active_o, illegal_cnt_o
    );

    modport slave (
        input  enable_i, drive_pos_i, drive_neg_i, brake_mode_i,
               deadtime_cycles_i, fault_n_i, fault_clear_i,
        output gate_ah_o, gate_al_o, gate_bh_o, gate_bl_o,
               fault_latched_o, dt_active_o, illegal_cnt_o
    );
endinterface

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver with dead-time insertion, shoot-through blocking and fault latch.
// Optional macro MIN_PULSE_EN stretches every conducting state to at least MIN_ON cycles.
module hbridge_deadtime #(
    parameter int DT_WIDTH  = 8,
    parameter int ILL_WIDTH = 8
`ifdef MIN_PULSE_EN
    ,
    parameter int MIN_ON    = 4
`endif
) (
    input logic               clk,
    input logic               reset,
    hbridge_deadtime_if.slave bus
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_FWD,
        ST_REV,
        ST_BRAKE,
        ST_DEADTIME,
        ST_FAULT
    } state_e;

    state_e               state_q, state_d, target;
    logic [DT_WIDTH-1:0]  dt_cnt_q, dt_cnt_d, dt_load;
    logic                 fault_meta_q, fault_sync_q;
    logic                 fault_latched_q, fault_latched_d;
    logic [ILL_WIDTH-1:0] illegal_cnt_q, illegal_cnt_d;
    logic [3:0]           gates_q, gates_d;  // {ah, al, bh, bl}
    logic                 dt_active_q;
    logic                 leave_ok;

    // Counter holds remaining cycles after the current one, so a request of 0 still yields one dead cycle.
    assign dt_load = (bus.deadtime_cycles_i == '0) ? '0
                   : bus.deadtime_cycles_i - DT_WIDTH'(1);

    always_comb begin
        target = ST_OFF;
        if (bus.enable_i) begin
            case ({bus.drive_pos_i, bus.drive_neg_i})
                2'b10:   target = ST_FWD;
                2'b01:   target = ST_REV;
                2'b00:   target = bus.brake_mode_i ? ST_BRAKE : ST_OFF;
                default: target = ST_OFF;
            endcase
        end
    end

`ifdef MIN_PULSE_EN
    localparam int OnW = $clog2(MIN_ON + 1);
    logic [OnW-1:0] on_cnt_q, on_cnt_d;

    always_comb begin
        on_cnt_d = on_cnt_q;
        if (state_d != state_q) begin
            on_cnt_d = OnW'(1);
        end else if (on_cnt_q != OnW'(MIN_ON)) begin
            on_cnt_d = on_cnt_q + OnW'(1);
        end
    end

    // Dropping enable is a shutdown request and skips the minimum on-time.
    assign leave_ok = (on_cnt_q >= OnW'(MIN_ON)) || !bus.enable_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_cnt_q <= '0;
        end else begin
            on_cnt_q <= on_cnt_d;
        end
    end
`else
    assign leave_ok = 1'b1;
`endif

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        dt_cnt_d        = dt_cnt_q;
        fault_latched_d = fault_latched_q;
        if (!fault_sync_q) begin
            state_d         = ST_FAULT;
            fault_latched_d = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: state_d = target;
                ST_FWD, ST_REV, ST_BRAKE: begin
                    if (target != state_q && leave_ok) begin
                        state_d  = ST_DEADTIME;
                        dt_cnt_d = dt_load;
                    end
                end
                ST_DEADTIME: begin
                    if (dt_cnt_q == '0) begin
                        state_d = target;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
                    end
                end
                ST_FAULT: begin
                    if (bus.fault_clear_i) begin
                        state_d         = ST_OFF;
                        fault_latched_d = 1'b0;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Gates decode the next state so they switch on the same edge as the state register.
    always_comb begin
        gates_d = 4'b0000;
        case (state_d)
            ST_FWD:   gates_d = 4'b1001;
            ST_REV:   gates_d = 4'b0110;
            ST_BRAKE: gates_d = 4'b0101;
            default:  gates_d = 4'b0000;
        endcase
    end

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (bus.drive_pos_i && bus.drive_neg_i && illegal_cnt_q != '1) begin
            illegal_cnt_d = illegal_cnt_q + ILL_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_OFF;
            dt_cnt_q        <= '0;
            fault_meta_q    <= 1'b1;
            fault_sync_q    <= 1'b1;
            fault_latched_q <= 1'b0;
            illegal_cnt_q   <= '0;
            gates_q         <= 4'b0000;
            dt_active_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            dt_cnt_q        <= dt_cnt_d;
            fault_meta_q    <= bus.fault_n_i;
            fault_sync_q    <= fault_meta_q;
            fault_latched_q <= fault_latched_d;
            illegal_cnt_q   <= illegal_cnt_d;
            gates_q         <= gates_d;
            dt_active_q     <= (state_d == ST_DEADTIME);
        end
    end

    assign bus.gate_ah_o       = gates_q[3];
    assign bus.gate_al_o       = gates_q[2];
    assign bus.gate_bh_o       = gates_q[1];
    assign bus.gate_bl_o       = gates_q[0];
    assign bus.fault_latched_o = fault_latched_q;
    assign bus.dt_active_o     = dt_active_q;
    assign bus.illegal_cnt_o   = illegal_cnt_q;

endmodule
